// File: rtl/shared_sop_pkg.sv
// Shared types and helpers for the runtime-programmable SOP engine.
// The optional error checker is enabled by defining SOP_ERR_CHECK_EN.
package shared_sop_pkg;

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2
  } sop_state_e;

  localparam int unsigned POP_W = 32;

  localparam int DEF_N_IN   = 4;
  localparam int DEF_N_OUT  = 3;
  localparam int DEF_N_PROD = 4;
  localparam int DEF_LPP    = 2;
  localparam int DEF_ET     = 1;

  // One config beat is {act, neg, pos}.
  function automatic int cfg_beat_w(input int n_in, input int n_out);
    return 2 * n_in + n_out;
  endfunction

  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_W; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/sop_product_term.sv
// One shared product: AND of the literals selected by pos (true) and neg (complemented).
// An empty mask or more than LPP literals yields a constant-0 product.
module sop_product_term
  import shared_sop_pkg::*;
#(
  parameter int N_IN = DEF_N_IN,
  parameter int LPP  = DEF_LPP
) (
  input  logic [N_IN-1:0] pos,
  input  logic [N_IN-1:0] neg,
  input  logic [N_IN-1:0] lits,
  output logic            prod,
  output logic            lpp_viol
);

  assign lpp_viol = popcount(POP_W'(pos | neg)) > LPP;

  // A bit set in both masks can never be satisfied, so overlap gives 0 without extra logic.
  assign prod = ~lpp_viol && (|(pos | neg))
             && ((lits & pos) == pos) && ((~lits & neg) == neg);

endmodule

// File: rtl/shared_sop_engine.sv
// Two-stage shared-product SOP evaluator with a beat-per-product config loader.
// Define SOP_ERR_CHECK_EN to compare each result against the exact sum of the two input halves.
module shared_sop_engine
  import shared_sop_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int N_PROD = DEF_N_PROD,
  parameter int LPP    = DEF_LPP,
  parameter int ET     = DEF_ET
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_valid,
  output logic                                   cfg_ready,
  input  logic [cfg_beat_w(N_IN, N_OUT)-1:0]     cfg_data,
  output logic                                   cfg_err,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [N_IN-1:0]                        in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [N_OUT-1:0]                       out_data,
  output logic                                   err_flag,
  output logic [15:0]                            err_count
);

  localparam int CNT_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;

  if (N_IN < 2 || (N_IN % 2) != 0) begin : g_bad_n_in
    $error("shared_sop_engine: N_IN must be even and >= 2");
  end

  sop_state_e       state, state_nx;
  logic [CNT_W-1:0] beat_cnt, beat_idx;
  logic [N_IN-1:0]  pos_q [N_PROD];
  logic [N_IN-1:0]  neg_q [N_PROD];
  logic [N_OUT-1:0] act_q [N_PROD];
  logic [N_PROD-1:0] prod_vec, viol_vec, s1_prod;
  logic [N_OUT-1:0] or_vec;
  logic             s1_valid, s1_adv, s2_adv, pipe_empty, cfg_fire, in_fire, last_beat;

  assign pipe_empty = ~s1_valid & ~out_valid;
  assign s2_adv     = ~out_valid | out_ready;
  assign s1_adv     = ~s1_valid | s2_adv;
  assign cfg_ready  = ~rst & ((state != RUN) | pipe_empty);
  assign cfg_fire   = cfg_valid & cfg_ready;
  assign in_ready   = (state == RUN) & ~cfg_valid & s1_adv;
  assign in_fire    = in_valid & in_ready;
  assign beat_idx   = (state == LOAD) ? beat_cnt : '0;
  assign last_beat  = beat_idx == CNT_W'(N_PROD - 1);

  // Config is wiped on LOAD entry, so the OR of per-product violations is sticky for one load.
  assign cfg_err = |viol_vec;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    if (cfg_fire) state_nx = last_beat ? RUN : LOAD;
  end

  // NOTE: configuration storage is reset because an unloaded engine must read as all-zero products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= UNCONF;
      beat_cnt <= '0;
      for (int k = 0; k < N_PROD; k++) begin
        pos_q[k] <= '0;
        neg_q[k] <= '0;
        act_q[k] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments; the later write to beat_idx wins over the wipe.
      state <= state_nx;
      if (cfg_fire) begin
        beat_cnt <= last_beat ? '0 : beat_idx + 1'b1;
        if (state != LOAD) begin
          for (int k = 0; k < N_PROD; k++) begin
            pos_q[k] <= '0;
            neg_q[k] <= '0;
            act_q[k] <= '0;
          end
        end
        pos_q[beat_idx] <= cfg_data[N_IN-1:0];
        neg_q[beat_idx] <= cfg_data[2*N_IN-1:N_IN];
        act_q[beat_idx] <= cfg_data[2*N_IN +: N_OUT];
      end
    end
  end

  for (genvar k = 0; k < N_PROD; k++) begin : g_term
    sop_product_term #(.N_IN(N_IN), .LPP(LPP)) u_term (
      .pos      (pos_q[k]),
      .neg      (neg_q[k]),
      .lits     (in_data),
      .prod     (prod_vec[k]),
      .lpp_viol (viol_vec[k])
    );
  end

  always_comb begin
    or_vec = '0;
    for (int j = 0; j < N_OUT; j++)
      for (int k = 0; k < N_PROD; k++)
        or_vec[j] = or_vec[j] | (s1_prod[k] & act_q[k][j]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_prod   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_fire;
        s1_prod  <= prod_vec;
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        out_data  <= s1_valid ? or_vec : '0;
      end
    end
  end

`ifdef SOP_ERR_CHECK_EN
  if (N_OUT != N_IN / 2 + 1) begin : g_bad_n_out
    $error("shared_sop_engine: SOP_ERR_CHECK_EN requires N_OUT == N_IN/2+1");
  end

  logic [N_IN-1:0]  s1_in;
  logic [N_OUT-1:0] exact, diff;
  logic             err_nx;

  assign exact  = N_OUT'(s1_in[N_IN/2-1:0]) + N_OUT'(s1_in[N_IN-1:N_IN/2]);
  assign diff   = (or_vec >= exact) ? or_vec - exact : exact - or_vec;
  assign err_nx = diff > N_OUT'(ET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_in     <= '0;
      err_flag  <= 1'b0;
      err_count <= '0;
    end else begin
      if (s1_adv) s1_in <= in_data;
      if (s2_adv) err_flag <= s1_valid & err_nx;
      if (out_valid && out_ready && err_flag && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end
`else
  if (ET < 0) begin : g_bad_et
    $error("shared_sop_engine: ET must be non-negative");
  end

  assign err_flag  = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_shared_sop_engine.sv
// Self-checking bench for shared_sop_engine against a behavioural SOP model.
// Honours SOP_ERR_CHECK_EN for the error-checker expectations.
module tb_shared_sop_engine;

  localparam int N_IN = 4, N_OUT = 3, N_PROD = 4, LPP = 2, ET = 1;
  localparam int CFG_W = 2 * N_IN + N_OUT;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid, cfg_ready, cfg_err;
  logic [CFG_W-1:0]  cfg_data;
  logic              in_valid, in_ready;
  logic [N_IN-1:0]   in_data;
  logic              out_valid, out_ready, err_flag;
  logic [N_OUT-1:0]  out_data;
  logic [15:0]       err_count;

  always #5 clk = ~clk;

  shared_sop_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .N_PROD(N_PROD), .LPP(LPP), .ET(ET)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_flag(err_flag), .err_count(err_count)
  );

  typedef struct { logic [N_OUT-1:0] data; logic err; } exp_t;

  int               n_checks = 0, n_fail = 0;
  logic [N_IN-1:0]  m_pos [N_PROD];
  logic [N_IN-1:0]  m_neg [N_PROD];
  logic [N_OUT-1:0] m_act [N_PROD];
  int               m_beat = 0, m_err_cnt = 0, out_fires = 0;
  logic             m_cfg_err = 1'b0, prev_stall = 1'b0;
  exp_t             exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lit_count(input logic [N_IN-1:0] p, input logic [N_IN-1:0] n);
    int c = 0;
    for (int i = 0; i < N_IN; i++) if (p[i] || n[i]) c++;
    return c;
  endfunction

  function automatic logic prod_model(input int k, input logic [N_IN-1:0] x);
    logic ok = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      if (m_pos[k][i] && !x[i]) ok = 1'b0;
      if (m_neg[k][i] && x[i])  ok = 1'b0;
    end
    return ok && lit_count(m_pos[k], m_neg[k]) > 0 && lit_count(m_pos[k], m_neg[k]) <= LPP;
  endfunction

  function automatic exp_t model(input logic [N_IN-1:0] x);
    exp_t e;
    e.data = '0;
    for (int j = 0; j < N_OUT; j++)
      for (int k = 0; k < N_PROD; k++)
        if (m_act[k][j] && prod_model(k, x)) e.data[j] = 1'b1;
`ifdef SOP_ERR_CHECK_EN
    begin
      int o, exact;
      o     = int'(e.data);
      exact = int'(x[N_IN/2-1:0]) + int'(x[N_IN-1:N_IN/2]);
      e.err = ((o > exact) ? o - exact : exact - o) > ET;
    end
`else
    e.err = 1'b0;
`endif
    return e;
  endfunction

  function automatic void model_cfg(input logic [CFG_W-1:0] cd);
    logic [N_IN-1:0] p, n;
    p = cd[N_IN-1:0];
    n = cd[2*N_IN-1:N_IN];
    if (m_beat == 0) m_cfg_err = 1'b0;
    m_pos[m_beat] = p;
    m_neg[m_beat] = n;
    m_act[m_beat] = cd[2*N_IN +: N_OUT];
    if (lit_count(p, n) > LPP) m_cfg_err = 1'b1;
    m_beat = (m_beat + 1) % N_PROD;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_beat = 0; m_err_cnt = 0; m_cfg_err = 1'b0; prev_stall = 1'b0;
    for (int k = 0; k < N_PROD; k++) begin
      m_pos[k] = '0; m_neg[k] = '0; m_act[k] = '0;
    end
  endfunction

  // One clock cycle: drive at negedge, check just after, account handshakes for the coming edge.
  task automatic step(input logic iv, input logic [N_IN-1:0] id, input logic ordy,
                      input logic cv, input logic [CFG_W-1:0] cd,
                      output bit in_acc, output bit cfg_acc);
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = ordy; cfg_valid = cv; cfg_data = cd;
    #1;
    in_acc  = in_valid && in_ready;
    cfg_acc = cfg_valid && cfg_ready;
    check("err_count", err_count, m_err_cnt);
    check("cfg_err", cfg_err, m_cfg_err);
    if (cv) check("in_ready_while_cfg", in_ready, 0);
    if (prev_stall) check("hold_valid", out_valid, 1);
    if (out_valid) begin
      if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
      else begin
        check("out_data", out_data, exp_q[0].data);
        check("err_flag", err_flag, exp_q[0].err);
      end
    end else check("err_flag_idle", err_flag, 0);
    prev_stall = out_valid && !ordy;
    if (out_valid && ordy && exp_q.size() > 0) begin
      if (exp_q[0].err && m_err_cnt != 65535) m_err_cnt++;
      void'(exp_q.pop_front());
      out_fires++;
    end
    if (in_acc)  exp_q.push_back(model(id));
    if (cfg_acc) model_cfg(cd);
  endtask

  task automatic idle();
    bit ia, ca;
    step(1'b0, '0, 1'b1, 1'b0, '0, ia, ca);
  endtask

  task automatic load_beat(input logic [CFG_W-1:0] cd);
    bit ia, ca;
    int n = 0;
    do begin step(1'b0, '0, 1'b1, 1'b1, cd, ia, ca); n++; end while (!ca && n < 50);
    if (!ca) check("cfg_accept_timeout", ca, 1);
  endtask

  task automatic load4(input logic [CFG_W-1:0] b0, input logic [CFG_W-1:0] b1,
                       input logic [CFG_W-1:0] b2, input logic [CFG_W-1:0] b3);
    load_beat(b0); load_beat(b1); load_beat(b2); load_beat(b3);
  endtask

  task automatic send(input logic [N_IN-1:0] d);
    bit ia, ca;
    int n = 0;
    do begin step(1'b1, d, 1'b1, 1'b0, '0, ia, ca); n++; end while (!ia && n < 50);
    if (!ia) check("in_accept_timeout", ia, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 50) begin idle(); n++; end
    check("drain_empty", exp_q.size(), 0);
    idle();
  endtask

  localparam logic [CFG_W-1:0] B0 = 11'b101_0000_1010, B1 = 11'b011_0010_1000,
                               B2 = 11'b001_1000_0100, B3 = 11'b011_1000_0010;

  initial begin
    logic [N_IN-1:0]  stream [5];
    logic [N_OUT-1:0] stream_out [4];
    int               fires_tab [6];
    bit               ia, ca;
    int               f0, idx, cyc;

    stream     = '{4'b0000, 4'b0100, 4'b0011, 4'b1000, 4'b1111};
    stream_out = '{3'b000, 3'b001, 3'b011, 3'b011};
    fires_tab  = '{0, 0, 1, 2, 3, 4};

    // Reset state
    rst = 1'b1; cfg_valid = 0; cfg_data = '0; in_valid = 0; in_data = '0; out_ready = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_err_count", err_count, 0);
    rst = 1'b0;
    idle();
    check("unconf_in_ready", in_ready, 0);
    check("unconf_cfg_ready", cfg_ready, 1);

    // Canonical load and single-vector latency
    load4(B0, B1, B2, B3);
    idle();
    check("cfg_err_clean", cfg_err, 0);
    check("run_in_ready", in_ready, 1);
    step(1'b1, 4'b1010, 1'b1, 1'b0, '0, ia, ca);
    check("lat_accept", ia, 1);
    idle();
    check("lat_c1_valid", out_valid, 0);
    idle();
    check("lat_c2_valid", out_valid, 1);
    check("lat_c2_data", out_data, 3'b101);
    idle();

    // Back-to-back stream at full rate
    f0 = out_fires;
    for (int s = 0; s < 6; s++) begin
      step(s < 4, (s < 4) ? stream[s] : 4'b0000, 1'b1, 1'b0, '0, ia, ca);
      if (s < 4) check("stream_accept", ia, 1);
      if (s >= 2) check("stream_out", out_data, stream_out[s-2]);
      check("stream_fires", out_fires - f0, fires_tab[s]);
    end

    // Same stream plus 1111 with a three-cycle output stall
    idx = 0; cyc = 0;
    while ((idx < 5 || exp_q.size() > 0) && cyc < 40) begin
      step(idx < 5, (idx < 5) ? stream[idx] : 4'b0000, !(cyc >= 2 && cyc < 5), 1'b0, '0, ia, ca);
      if (ia) idx++;
      cyc++;
    end
    check("stall_all_sent", idx, 5);
    check("stall_all_out", exp_q.size(), 0);
    idle();

    // Product 0 deactivated: 1010 now yields 000 (an error when checking is enabled)
    load4(11'b000_0000_1010, B1, B2, B3);
    send(4'b1010);
    drain();
`ifdef SOP_ERR_CHECK_EN
    check("err_count_one", err_count, 1);
`else
    check("err_count_off", err_count, 0);
`endif

    // Over-wide product: flagged and reads 0 for every input
    load4(B0, B1, 11'b111_0000_0111, B3);
    idle();
    check("cfg_err_viol", cfg_err, 1);
    for (int v = 0; v < 16; v++) send(4'(v));
    drain();

    // Reconfig request with two results in flight
    send(4'b1010);
    send(4'b0011);
    step(1'b1, 4'b0100, 1'b1, 1'b1, B0, ia, ca);
    check("busy_cfg_ready", cfg_ready, 0);
    check("busy_no_input", ia, 0);
    load_beat(B0);
    check("drained_at_cfg", exp_q.size(), 0);
    load_beat(B1); load_beat(B2); load_beat(B3);
    idle();
    check("cfg_err_cleared", cfg_err, 0);

    // Random configurations and traffic
    for (int r = 0; r < 6; r++) begin
      logic [CFG_W-1:0] rb [N_PROD];
      for (int k = 0; k < N_PROD; k++)
        rb[k] = {3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                 4'($urandom_range(0, 15) & $urandom_range(0, 15))};
      load4(rb[0], rb[1], rb[2], rb[3]);
      for (int c = 0; c < 150; c++)
        step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3) != 0, 1'b0, '0, ia, ca);
      drain();
    end

    // Reset in the middle of a load
    load_beat(B0);
    load_beat(B1);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_data = B2;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_cfg_ready", cfg_ready, 0);
    check("mid_rst_cfg_err", cfg_err, 0);
    check("mid_rst_err_count", err_count, 0);
    check("mid_rst_err_flag", err_flag, 0);
    @(negedge clk);
    rst = 1'b0; cfg_valid = 1'b0;
    idle();
    check("post_rst_in_ready", in_ready, 0);
    load_beat(B0); load_beat(B1); load_beat(B2);
    idle();
    check("partial_in_ready", in_ready, 0);
    load_beat(B3);
    idle();
    check("reloaded_in_ready", in_ready, 1);
    send(4'b1010);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
